// File: rtl/result_reader.sv
`default_nettype none
// ============================================================================
// Module : result_reader
// Drains result_mem from address 0 to MEM_DEPTH-1 through a 1-cycle read port
// and streams {addr, data} beats out on valid/ready via a 2-entry buffer.
// Rev    : 1.0 - initial release
// ============================================================================
module result_reader #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         rd_en_o,
  output logic [$clog2(MEM_DEPTH)-1:0] rd_addr_o,
  input  logic [MEM_WIDTH-1:0]         rd_data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [MEM_WIDTH-1:0]         data_o,
  output logic [$clog2(MEM_DEPTH)-1:0] addr_o
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [ADDR_W-1:0]    r_issue_cnt;
  logic                 r_inflight;
  logic [ADDR_W-1:0]    r_inflight_addr;
  logic [MEM_WIDTH-1:0] r_buf_data [2];
  logic [ADDR_W-1:0]    r_buf_addr [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  logic w_start;
  logic w_pop;
  logic w_push;
  logic w_issue;
  logic w_last_issue;
  logic w_drained;

  assign w_start = (r_state == S_IDLE) && start_i;
  assign w_pop   = valid_o && ready_i;
  assign w_push  = r_inflight;

  // Credit rule: occupancy + in-flight - pop < 2 keeps the buffer from overflowing.
  assign w_issue = (r_state == S_READ) &&
                   (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_last_issue = w_issue && (r_issue_cnt == C_LAST_ADDR);

  // Look ahead through the current pop so done follows the last handshake directly.
  assign w_drained = !r_inflight &&
                     ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = (r_state == S_DONE);
  assign rd_en_o   = w_issue;
  assign rd_addr_o = w_issue ? r_issue_cnt : '0;
  assign valid_o   = (r_count != 2'd0);
  assign data_o    = valid_o ? r_buf_data[r_rd_ptr] : '0;
  assign addr_o    = valid_o ? r_buf_addr[r_rd_ptr] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_i)      r_state <= S_READ;
        S_READ:  if (w_last_issue) r_state <= S_DRAIN;
        S_DRAIN: if (w_drained)    r_state <= S_DONE;
        S_DONE:                    r_state <= S_IDLE;
        default:                   r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issue_cnt     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_issue_cnt;
      end
      if (w_start) begin
        r_issue_cnt <= '0;
      end else if (w_issue && !w_last_issue) begin
        r_issue_cnt <= r_issue_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_addr[i] <= '0;
      end
    end else if (w_start) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= rd_data_i;
        r_buf_addr[r_wr_ptr] <= r_inflight_addr;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_result_reader
// Directed and randomized checks of result_reader against an in-order drain model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_result_reader;

  localparam int W = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         ready = 1'b0;
  logic         busy, done, rd_en, valid;
  logic [2:0]   rd_addr, addr;
  logic [W-1:0] rd_data = '0;
  logic [W-1:0] data;

  logic         start2 = 1'b0;
  logic         busy2, done2, rd_en2, valid2;
  logic [0:0]   rd_addr2, addr2;
  logic [W-1:0] rd_data2 = '0;
  logic [W-1:0] data2;

  result_reader #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .valid_o(valid), .ready_i(ready), .data_o(data), .addr_o(addr)
  );

  result_reader #(.MEM_WIDTH(W), .MEM_DEPTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .rd_en_o(rd_en2), .rd_addr_o(rd_addr2), .rd_data_i(rd_data2),
    .valid_o(valid2), .ready_i(ready), .data_o(data2), .addr_o(addr2)
  );

  // Memory models: requests captured mid-cycle, data returned on the next cycle.
  logic [W-1:0] mem  [D];
  logic [W-1:0] mem2 [2];
  logic         s_en = 1'b0, s_en2 = 1'b0;
  logic [2:0]   s_addr = '0;
  logic [0:0]   s_addr2 = '0;

  always @(negedge clk) begin
    s_en    <= rd_en;
    s_addr  <= rd_addr;
    s_en2   <= rd_en2;
    s_addr2 <= rd_addr2;
  end

  always @(posedge clk) begin
    rd_data  <= s_en  ? mem[s_addr]   : $urandom;
    rd_data2 <= s_en2 ? mem2[s_addr2] : $urandom;
  end

  int checks = 0;
  int errors = 0;
  int n_iss, n_acc, n_done, cyc, first_beat, done_cyc;
  logic         hold;
  logic [W-1:0] h_data;
  logic [2:0]   h_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle of the depth-8 DUT, then advance to just past the next edge.
  task automatic step();
    @(negedge clk);
    if (rd_en) begin
      chk("rd_addr_order", rd_addr, n_iss);
      n_iss++;
    end
    if (hold) begin
      chk("hold_valid", valid, 1);
      chk("hold_data", data, h_data);
      chk("hold_addr", addr, h_addr);
    end
    if (valid && ready) begin
      if (n_acc == 0) first_beat = cyc;
      chk("beat_addr", addr, n_acc);
      chk("beat_data", data, (n_acc < D) ? mem[n_acc] : 'x);
      n_acc++;
    end
    chk("credit_le2", (n_iss - n_acc) <= 2, 1);
    hold   = valid && !ready;
    h_data = data;
    h_addr = addr;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready high, 1: ready low in C3..C7, 2: random 50%
  task automatic run(input int mode, input bit poke);
    n_iss = 0; n_acc = 0; n_done = 0; cyc = 0;
    first_beat = -1; done_cyc = -1; hold = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    while (n_done == 0 && cyc < 300) begin
      if (cyc == 1) chk("busy_c1", busy, 1);
      if (mode == 1 && cyc == 8) chk("stall_reads", n_iss, 2);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = !(cyc >= 3 && cyc <= 7);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      start = poke && (cyc == 4 || cyc == 11);
      step();
    end
    start = 1'b0;
    ready = 1'b1;
    chk("busy_after_done", busy, 0);
    repeat (4) step();
    chk("total_beats", n_acc, D);
    chk("total_reads", n_iss, D);
    chk("done_pulses", n_done, 1);
    if (mode == 0) begin
      chk("first_beat_cycle", first_beat, 3);
      chk("done_cycle", done_cyc, 11);
    end
    if (mode == 1) chk("stall_first_beat", first_beat, 8);
  endtask

  initial begin
    mem[0] = 5; mem[1] = 3; mem[2] = 9; mem[3] = 0;
    mem[4] = 7; mem[5] = 1; mem[6] = 2; mem[7] = 8;
    mem2[0] = 4; mem2[1] = 6;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 1'b0);
    run(1, 1'b0);
    run(0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < D; i++) mem[i] = $urandom;
      run(2, 1'b0);
    end

    // Reset asserted in C5 of a run
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_data", data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_valid", valid, 0);
      chk("postrst_rd_en", rd_en, 0);
      chk("postrst_done", done, 0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < D; i++) mem[i] = $urandom;
    run(0, 1'b0);

    // Minimum depth: beats in C3, C4 and done in C5
    start2 = 1'b1;
    ready  = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("d2_rd_en", rd_en2, (c == 1 || c == 2));
      chk("d2_valid", valid2, (c == 3 || c == 4));
      chk("d2_done", done2, (c == 5));
      chk("d2_busy", busy2, (c >= 1 && c <= 5));
      if (c == 3 || c == 4) begin
        chk("d2_addr", addr2, c - 3);
        chk("d2_data", data2, mem2[c-3]);
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_reader.md
# result_reader

Sequential read-out engine for `result_mem`: the reading end of the memory that `operation` writes. After a start pulse it reads every entry, from address 0 to `MEM_DEPTH-1`, through a synchronous 1-cycle-latency read port. It streams each word out on a valid/ready interface tagged with its address, using a 2-entry buffer to absorb backpressure. The bench and the DPI scoreboard use it to drain results in order instead of probing memory hierarchically.

## Interface

**Parameters**
- `MEM_WIDTH`, default 32: data word width.
- `MEM_DEPTH`, default 8: number of entries to drain. Must be ≥ 2; power of two not required.

**Ports**
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  1-cycle start request; sampled only in IDLE.
- `busy_o`  out  1  high from the cycle after start is accepted until `done_o`, inclusive.
- `done_o`  out  1  1-cycle pulse after the last output handshake.
- `rd_en_o`  out  1  memory read strobe.
- `rd_addr_o`  out  `$clog2(MEM_DEPTH)`  memory read address; valid when `rd_en_o` is high.
- `rd_data_i`  in  `MEM_WIDTH`  read data, valid exactly 1 cycle after `rd_en_o`.
- `valid_o`  out  1  output beat available.
- `ready_i`  in  1  sink accepts the beat.
- `data_o`  out  `MEM_WIDTH`  beat data.
- `addr_o`  out  `$clog2(MEM_DEPTH)`  memory address the beat was read from.

## Operation

- **States:** IDLE, READ, DRAIN, DONE.
- **IDLE:** when `start_i` is high, go to READ and clear the issue counter, in-flight flag and buffer. Otherwise stay.
- **READ:** drive `rd_en_o` when occupancy + in-flight − pop < 2, where pop = `valid_o && ready_i` this cycle.
  - Each issue drives `rd_addr_o` = issue counter, then increments the counter.
  - After the issue at address `MEM_DEPTH-1`, go to DRAIN. The counter never wraps.
- **In-flight flag:** set on the edge after an issue. The returned `rd_data_i` and its address are pushed into the buffer on the following edge.
- **DRAIN:** no further reads. When the buffer is empty and nothing is in flight, go to DONE.
- **DONE:** `done_o` = 1 for one cycle, then IDLE.
- **Buffer:** 2-entry FIFO of {addr, data}.
  - `valid_o` is high exactly when the buffer is non-empty; `data_o`/`addr_o` show the head.
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
  - Overflow is impossible by the credit rule; verification asserts occupancy ≤ 2.
- **Backpressure:** while `valid_o && !ready_i`, `valid_o`, `data_o` and `addr_o` hold stable.
- **Ordering:** beats emerge with `addr_o` = 0, 1, …, `MEM_DEPTH-1`; none dropped or duplicated.
- **`start_i` outside IDLE:** ignored, including in DONE.
- **Reset (anytime, mid-run included):** go to IDLE, empty the buffer, drop any in-flight read. The returning `rd_data_i` is discarded.
- **Reset values:** `busy_o`, `done_o`, `rd_en_o`, `valid_o` = 0; `rd_addr_o`, `addr_o`, `data_o` = 0.

## Timing

- `start_i` sampled at edge E0. READ is entered and `rd_en_o` = 1 with address 0 in cycle C1.
- `rd_data_i` arrives in C2 and is pushed at the end of C2. `valid_o` rises in C3: 3-cycle start-to-first-beat latency.
- With `ready_i` held high: one read per cycle (C1…C`MEM_DEPTH`) and one beat per cycle (C3…C`MEM_DEPTH`+2).
  - `done_o` pulses in C`MEM_DEPTH`+3 and `busy_o` drops after it.
  - For `MEM_DEPTH` = 8: beats C3–C10, done C11.
- With `ready_i` low, reads stall once occupancy + in-flight reaches 2. Issue resumes in the same cycle `ready_i` returns high.
- `busy_o` = 1 in READ, DRAIN and DONE.

## Test plan

- **Back-to-back:** memory 0..7 = {5,3,9,0,7,1,2,8}, `ready_i`=1, start → beats (addr,data) (0,5)…(7,8) in C3–C10; `done_o` pulses at C11 only.
- **Stall:** same memory, `ready_i`=0 C3–C7 → `valid_o` held with (0,5) stable; only 2 reads issued before stall. Release → remaining 8 beats in order, no loss or duplicates.
- **Random backpressure:** `ready_i` random 50%, 3 runs → beats match the DPI golden model, addresses 0..7 in order, occupancy never > 2.
- **Start while busy:** `start_i` pulsed in C4 and during DONE → ignored; exactly 8 beats, one `done_o`.
- **Reset mid-run:** `rst_ni` low at C5 for 1 cycle → all outputs 0 immediately, no spurious beat after release. New start gives full 0..7 sequence.
- **Min depth:** `MEM_DEPTH`=2, data {4,6} → beats (0,4),(1,6) in C3,C4; done C5.
